lcd_write_queue: RTL

//  Memory-mapped write buffer that sits directly upstream of the LCD controller.
//  CPU stores command/data bytes into a FIFO without stalling.
//  A drain FSM replays each entry as a one-cycle bus write at the LCD controller's rate.

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_entry_fifo.sv | 73 +++++++
 rtl/lcd_write_queue.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write queue.
// INIT_SEQ is the power-up command sequence used when LCD_INIT_SEQ_EN is defined.
package lcd_pkg;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} drain_state_t;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_BUSY  = 3;
  localparam int ST_LEVEL = 8;

  localparam int INIT_LEN = 4;
  localparam logic [7:0] INIT_SEQ [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic lcd_entry_t init_entry(input int idx);
    lcd_entry_t e;
    e = '0;
    if (idx < INIT_LEN) e.data = INIT_SEQ[idx];
    return e;
  endfunction

endpackage

// File: rtl/lcd_entry_fifo.sv
// Synchronous FIFO of {rs, byte} entries with level count and async reset.
// With LCD_INIT_SEQ_EN defined, reset leaves the LCD init commands preloaded.
module lcd_entry_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     ACLK,
  input  logic                     RESET,
  input  logic                     push,
  input  lcd_entry_t               push_entry,
  input  logic                     pop,
  output lcd_entry_t               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

`ifdef LCD_INIT_SEQ_EN
  localparam logic [PW-1:0] WR_RST  = PW'(INIT_LEN);
  localparam logic [LW-1:0] LVL_RST = LW'(INIT_LEN);
`else
  localparam logic [PW-1:0] WR_RST  = '0;
  localparam logic [LW-1:0] LVL_RST = '0;
`endif

  lcd_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_en;
  logic          pop_en;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_en  = pop && !empty;
  // A push into a full FIFO is only taken when a pop frees a slot in the same cycle
  assign push_en = push && (!full || pop_en);
  assign head    = mem[rd_ptr];

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= WR_RST;
      rd_ptr <= '0;
      level  <= LVL_RST;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef LCD_INIT_SEQ_EN
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_entry(i);
    end else if (push_en) begin
      mem[wr_ptr] <= push_entry;
    end
  end
`else
  always_ff @(posedge ACLK) begin
    if (push_en) mem[wr_ptr] <= push_entry;
  end
`endif

endmodule

// File: rtl/lcd_write_queue.sv
// Memory-mapped write buffer feeding the LCD controller at a fixed strobe pitch.
// Optional feature: LCD_INIT_SEQ_EN preloads the LCD init sequence on reset.
//
// state | meaning
// IDLE  | waiting for a queued entry; pops the head into the output registers
// ISSUE | LCD_WRSTB_O high for this one cycle; gap counter loads
// WAIT  | gap counter runs down so strobes land exactly GAP_CYCLES apart
module lcd_write_queue
  import lcd_pkg::*;
#(
  parameter logic [31:0] BASEADDRESS = 32'h5000_0010,
  parameter logic [31:0] LCD_BASE    = 32'h5000_0000,
  parameter int          DEPTH       = 16,
  parameter int          GAP_CYCLES  = 100_100
) (
  input  logic        ACLK,
  input  logic        RESET,
  input  logic [31:0] DATA_I,
  input  logic [31:0] ADDR,
  input  logic        WRSTB,
  input  logic        RDSTB,
  output logic [31:0] DATA_O,
  output logic [31:0] LCD_DATA_O,
  output logic [31:0] LCD_ADDR_O,
  output logic        LCD_WRSTB_O
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 2);

  drain_state_t  state;
  drain_state_t  state_nxt;
  logic [CW-1:0] gap_cnt;
  logic          push_rs;
  logic          push_req;
  logic          stat_rd;
  logic          ovf_set;
  logic          overflow;
  logic          pop;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  lcd_entry_t    head;
  lcd_entry_t    push_entry;
  logic [31:0]   status;
  logic          unused_data_hi;

  assign unused_data_hi = ^DATA_I[31:8];

  assign push_rs    = (ADDR == BASEADDRESS + 32'd1);
  assign push_req   = WRSTB && ((ADDR == BASEADDRESS) || push_rs);
  assign stat_rd    = RDSTB && (ADDR == BASEADDRESS + 32'd2);
  assign ovf_set    = push_req && full && !pop;
  assign push_entry = '{rs: push_rs, data: DATA_I[7:0]};

  lcd_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .ACLK       (ACLK),
    .RESET      (RESET),
    .push       (push_req),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .level      (level)
  );

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT;
      // Leaving on the last count keeps IDLE inside the GAP_CYCLES pitch
      WAIT:    if (gap_cnt <= CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      gap_cnt <= '0;
    end else if (state == ISSUE) begin
      gap_cnt <= GAP_LOAD;
    end else if ((state == WAIT) && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      LCD_WRSTB_O <= 1'b0;
      LCD_ADDR_O  <= '0;
      LCD_DATA_O  <= '0;
    end else begin
      LCD_WRSTB_O <= pop;
      if (pop) begin
        LCD_ADDR_O <= LCD_BASE + {31'd0, head.rs};
        LCD_DATA_O <= {24'd0, head.data};
      end
    end
  end

  always_comb begin
    status                = '0;
    status[ST_EMPTY]      = empty;
    status[ST_FULL]       = full;
    status[ST_OVF]        = overflow;
    status[ST_BUSY]       = (state != IDLE);
    status[ST_LEVEL +: LW] = level;
  end

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      overflow <= 1'b0;
      DATA_O   <= '0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (stat_rd) overflow <= 1'b0;
      if (stat_rd) DATA_O <= status;
    end
  end

endmodule
